// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states and size helpers for the convolution stream sequencer.
//   state_e    : IDLE / FILL / RUN / FLUSH sequencer states
//   r_of       : kernel radius R = (N-1)/2
//   filt_lat_f : default filter latency, LINE_WIDTH*R + R + 2 enables
//   cnt_w      : width of a frame pixel counter, $clog2(LINE_WIDTH*FRAME_HEIGHT+1)
//   pos_w      : width of a coordinate that ranges over 0..n-1
package conv_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;
  function automatic int r_of(input int n);
    return (n - 1) / 2;
  endfunction
  function automatic int filt_lat_f(input int n, input int lw);
    return lw * r_of(n) + r_of(n) + 2;
  endfunction
  function automatic int cnt_w(input int lw, input int fh);
    return $clog2(lw * fh + 1);
  endfunction
  function automatic int pos_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pix_pos_counter.sv
// pix_pos_counter: raster x/y position counter that wraps at the end of each line and frame.
//   clk, rst : clock, synchronous active-low reset
//   en_i     : advance one pixel
//   x_o, y_o : current column / row
//   eol_o    : current pixel is the last of its line
//   last_o   : current pixel is the last of the frame
module pix_pos_counter import conv_pkg::*; #(
  parameter int W = 640,
  parameter int H = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  output logic [pos_w(W)-1:0]  x_o,
  output logic [pos_w(H)-1:0]  y_o,
  output logic                 eol_o,
  output logic                 last_o
);
  localparam int XW = pos_w(W);
  localparam int YW = pos_w(H);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  assign eol_o  = x_q == XW'(W - 1);
  assign last_o = eol_o && y_q == YW'(H - 1);
  assign x_o    = x_q;
  assign y_o    = y_q;
  always_comb begin
    x_d = en_i ? (eol_o ? '0 : x_q + 1'b1) : x_q;
    y_d = en_i && eol_o ? (last_o ? '0 : y_q + 1'b1) : y_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: sequences an NxN convolution filter between a pixel stream and a marked output stream.
//   clk, rst                      : clock, synchronous active-low reset (shared with the filter)
//   in_valid/in_ready/in_sof/in_data : input pixel stream, in_sof marks a frame's first pixel
//   filt_en/filt_data/filt_result : filter clock-enable, data in, centred result out
//   out_valid/out_ready/out_data  : filtered pixel stream
//   out_sof/out_eol/out_eof       : frame start / line end / frame end markers
//   busy                          : sequencer is inside a frame
//   sof_err                       : sticky, in_sof arrived mid-frame
// Build option: define BORDER_ZERO_EN to zero results whose kernel window crosses the frame edge.
module conv_stream_ctrl import conv_pkg::*; #(
  parameter int N            = 3,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PRECISION    = 31,
  parameter int FILT_LAT     = filt_lat_f(N, LINE_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [PRECISION-1:0] in_data,
  output logic                 filt_en,
  output logic [PRECISION-1:0] filt_data,
  input  logic [PRECISION-1:0] filt_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRECISION-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 sof_err
);
  localparam int CW = cnt_w(LINE_WIDTH, FRAME_HEIGHT);
  localparam int XW = pos_w(LINE_WIDTH);
  localparam int YW = pos_w(FRAME_HEIGHT);
  localparam logic [CW-1:0] LAT_C = CW'(FILT_LAT);
  localparam logic [CW-1:0] TOT_C = CW'(LINE_WIDTH * FRAME_HEIGHT);
  state_e        state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, flush_cnt_q, flush_cnt_d;
  logic          out_valid_q, out_valid_d, sof_err_q, sof_err_d;
  logic          slot_free, out_eol_raw, out_last;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  // The filter only shifts when the output slot can take its result, so filt_result
  // stays put while a presented output waits for out_ready.
  assign slot_free = !out_valid_q || out_ready;
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_cnt_q;
    sof_err_d   = sof_err_q;
    in_ready    = 1'b0;
    filt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        filt_en  = in_valid && in_sof;
        if (filt_en) begin
          in_cnt_d = CW'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        filt_en  = in_valid;
        if (filt_en) begin
          in_cnt_d  = in_cnt_q + 1'b1;
          sof_err_d = sof_err_q || in_sof;
          state_d   = in_cnt_d == LAT_C ? RUN : FILL;
        end
      end
      RUN: begin
        in_ready = slot_free;
        filt_en  = in_valid && slot_free;
        if (filt_en) begin
          in_cnt_d  = in_cnt_q + 1'b1;
          sof_err_d = sof_err_q || in_sof;
          state_d   = in_cnt_d == TOT_C ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        filt_en = slot_free;
        if (filt_en) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_d == LAT_C) begin
            flush_cnt_d = '0;
            in_cnt_d    = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (filt_en && (state_q == RUN || state_q == FLUSH)) || (out_valid_q && !out_ready);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      sof_err_q   <= sof_err_d;
    end
  end
  pix_pos_counter #(.W(LINE_WIDTH), .H(FRAME_HEIGHT)) u_pos (
    .clk    (clk),
    .rst    (rst),
    .en_i   (out_valid_q && out_ready),
    .x_o    (out_x),
    .y_o    (out_y),
    .eol_o  (out_eol_raw),
    .last_o (out_last)
  );
  assign filt_data = state_q == FLUSH ? '0 : in_data;
  assign out_valid = out_valid_q;
  assign out_sof   = out_valid_q && out_x == '0 && out_y == '0;
  assign out_eol   = out_valid_q && out_eol_raw;
  assign out_eof   = out_valid_q && out_last;
  assign busy      = state_q != IDLE;
  assign sof_err   = sof_err_q;
`ifdef BORDER_ZERO_EN
  localparam int R = r_of(N);
  logic border;
  assign border   = out_x < XW'(R) || out_x >= XW'(LINE_WIDTH - R) ||
                    out_y < YW'(R) || out_y >= YW'(FRAME_HEIGHT - R);
  assign out_data = border ? '0 : filt_result;
`else
  assign out_data = filt_result;
`endif
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb_conv_stream_ctrl: randomized self-checking bench for conv_stream_ctrl with a behavioural filter.
module tb_conv_stream_ctrl;
  localparam int LW = 8, FH = 4, NK = 3, P = 31, FLAT = 11, TOT = LW * FH;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [P-1:0] in_data = '0;
  logic in_ready, filt_en, out_valid, out_sof, out_eol, out_eof, busy, sof_err;
  logic [P-1:0] filt_data, filt_result, out_data;
  always #5 clk = ~clk;
  conv_stream_ctrl #(.N(NK), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .PRECISION(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .filt_en(filt_en), .filt_data(filt_data), .filt_result(filt_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .sof_err(sof_err)
  );
  // Filter model: every enable shifts one sample in; FLAT enables after a sample entered,
  // the result for that centre sample is 3*centre + right neighbour + pixel below.
  logic [P-1:0] hist [0:4095];
  int fk = 0;
  always @(posedge clk) begin
    if (!rst) fk = 0;
    else if (filt_en) begin
      hist[fk] = filt_data;
      fk++;
    end
    if (fk - 1 - FLAT >= 0)
      filt_result = P'(3 * hist[fk-1-FLAT] + hist[fk-FLAT] + hist[fk-1-FLAT+LW]);
    else
      filt_result = '0;
  end
  int chk = 0, pass = 0;
  int acc_cnt, fe_cnt, first_acc;
  logic last_acc, hold_pend;
  logic [P-1:0] hold_d;
  logic [2:0] hold_m;
  logic [P-1:0] got_d[$];
  logic [2:0] got_m[$];
  logic [P-1:0] pix [0:TOT-1];
  task automatic cyc();
    @(negedge clk);
    last_acc = rst && in_valid && in_ready;
    if (rst) begin
      if (out_valid && first_acc < 0) first_acc = acc_cnt;
      if (last_acc) acc_cnt++;
      if (filt_en) fe_cnt++;
      if (hold_pend) begin
        chk++;
        if (out_valid !== 1'b1 || out_data !== hold_d || {out_sof, out_eol, out_eof} !== hold_m)
          $display("FAIL hold_stable: valid=%b data=%0d mk=%b, need valid=1 data=%0d mk=%b",
                   out_valid, out_data, {out_sof, out_eol, out_eof}, hold_d, hold_m);
        else pass++;
      end
      if (out_valid && !out_ready) begin
        chk++;
        if (filt_en !== 1'b0) $display("FAIL en_while_stalled: filt_en=%b need 0", filt_en);
        else pass++;
      end
      hold_pend = out_valid && !out_ready;
      hold_d    = out_data;
      hold_m    = {out_sof, out_eol, out_eof};
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_m.push_back({out_sof, out_eol, out_eof});
      end
    end else hold_pend = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    got_d.delete();
    got_m.delete();
    acc_cnt = 0;
    fe_cnt = 0;
    first_acc = -1;
    hold_pend = 1'b0;
  endtask
  task automatic gen_frame(input bit konst);
    for (int i = 0; i < TOT; i++) pix[i] = konst ? P'(100) : P'($urandom_range(255));
  endtask
  function automatic logic [P-1:0] px(input int j);
    return j < TOT ? pix[j] : '0;
  endfunction
  function automatic logic [P-1:0] exp_d(input int i);
`ifdef BORDER_ZERO_EN
    if (i % LW < 1 || i % LW >= LW - 1 || i / LW < 1 || i / LW >= FH - 1) return '0;
`endif
    return P'(3 * px(i) + px(i + 1) + px(i + LW));
  endfunction
  task automatic drive_frame(input int bad, input int pct, input int gap, input int stop_at);
    int i = 0, n = 0;
    while (i < stop_at && n < 3000) begin
      in_valid  = $urandom_range(99) >= gap;
      in_sof    = i == 0 || i == bad;
      in_data   = pix[i];
      out_ready = $urandom_range(99) < pct;
      cyc();
      if (last_acc) i++;
      n++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask
  task automatic drain(input int pct);
    int n = 0;
    while (got_d.size() < TOT && n < 2000) begin
      out_ready = $urandom_range(99) < pct;
      in_data   = P'($urandom);
      cyc();
      n++;
    end
    out_ready = 1'b1;
    cyc();
    cyc();
  endtask
  task automatic check_frame(input string tag);
    chk++;
    if (got_d.size() != TOT) $display("FAIL %s out_count: got %0d need %0d", tag, got_d.size(), TOT);
    else pass++;
    for (int i = 0; i < got_d.size() && i < TOT; i++) begin
      chk++;
      if (got_d[i] !== exp_d(i)) $display("FAIL %s data[%0d]: got %0d need %0d", tag, i, got_d[i], exp_d(i));
      else pass++;
      chk++;
      if (got_m[i] !== {i == 0, i % LW == LW - 1, i == TOT - 1})
        $display("FAIL %s markers[%0d]: got %b need %b", tag, i, got_m[i], {i == 0, i % LW == LW - 1, i == TOT - 1});
      else pass++;
    end
    chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL %s idle_after: busy=%b valid=%b need 0 0", tag, busy, out_valid);
    else pass++;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    cyc();
    cyc();
    chk++;
    if ({busy, out_valid, filt_en, sof_err, in_ready} !== 5'b00001)
      $display("FAIL reset_state: busy/valid/en/err/ready=%b need 00001", {busy, out_valid, filt_en, sof_err, in_ready});
    else pass++;
    rst = 1'b1;
    cyc();
  endtask
  task automatic test_basic(input string tag);
    clear_mon();
    gen_frame(1'b0);
    drive_frame(-1, 100, 0, TOT);
    drain(100);
    chk++;
    if (first_acc !== FLAT + 1) $display("FAIL %s first_valid_accepts: got %0d need %0d", tag, first_acc, FLAT + 1);
    else pass++;
    chk++;
    if (sof_err !== 1'b0) $display("FAIL %s sof_err: got %b need 0", tag, sof_err);
    else pass++;
    check_frame(tag);
  endtask
  task automatic test_idle_discard();
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sof = 1'b0;
      in_data = P'($urandom);
      cyc();
      chk++;
      if (last_acc !== 1'b1) $display("FAIL idle_accept[%0d]: got %b need 1", i, last_acc);
      else pass++;
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk++;
    if (fe_cnt != 0 || got_d.size() != 0 || busy !== 1'b0)
      $display("FAIL idle_discard: enables=%0d outputs=%0d busy=%b need 0 0 0", fe_cnt, got_d.size(), busy);
    else pass++;
  endtask
  task automatic test_backpressure();
    clear_mon();
    gen_frame(1'b0);
    drive_frame(-1, 50, 25, TOT);
    drain(50);
    check_frame("backpressure");
  endtask
  task automatic test_sof_err();
    clear_mon();
    gen_frame(1'b0);
    drive_frame(20, 100, 0, TOT);
    drain(100);
    chk++;
    if (sof_err !== 1'b1) $display("FAIL sof_err_set: got %b need 1", sof_err);
    else pass++;
    check_frame("sof_err");
  endtask
  task automatic test_mid_reset();
    clear_mon();
    gen_frame(1'b0);
    drive_frame(-1, 100, 0, 15);
    chk++;
    if (busy !== 1'b1 || out_valid !== 1'b1) $display("FAIL pre_reset_run: busy=%b valid=%b need 1 1", busy, out_valid);
    else pass++;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk++;
    if ({busy, out_valid, filt_en, sof_err} !== 4'b0000)
      $display("FAIL mid_reset_state: busy/valid/en/err=%b need 0000", {busy, out_valid, filt_en, sof_err});
    else pass++;
    cyc();
    test_basic("after_reset");
  endtask
  task automatic test_const();
    clear_mon();
    gen_frame(1'b1);
    drive_frame(-1, 100, 0, TOT);
    drain(100);
    check_frame("const100");
  endtask
  initial begin
    test_reset();
    test_basic("basic");
    test_idle_discard();
    test_backpressure();
    test_sof_err();
    test_mid_reset();
    test_const();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
